// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit.
//   SZ_*          : req_size encodings (SZ_RSVD is rejected as an error)
//   state_e       : LSU control states
//   is_misaligned : 1 when a half/word access is not naturally aligned
package dmem_lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   typedef enum logic [1:0] {IDLE, ACCESS, MERGE_WR, RESP} state_e;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         SZ_HALF: return addr_lo[0];
         SZ_WORD: return addr_lo != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the LSU (little-endian).
//   word        : word currently read from memory
//   addr_lo     : byte offset within the word
//   size        : access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   uns         : 1 = zero-extend loads, 0 = sign-extend
//   wdata       : right-aligned store data
//   load_ext    : selected lane, extended to 32 bits
//   merged_word : word with the target lane replaced by wdata
module dmem_lane_align
   import dmem_lsu_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [31:0] wdata,
   output logic [31:0] load_ext,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   assign byte_sel = word[{addr_lo, 3'b000} +: 8];
   assign half_sel = word[{addr_lo[1], 4'b0000} +: 16];

   always_comb begin
      load_ext = word;
      case (size)
         SZ_BYTE: load_ext = {{24{~uns & byte_sel[7]}}, byte_sel};
         SZ_HALF: load_ext = {{16{~uns & half_sel[15]}}, half_sel};
         default: load_ext = word;
      endcase
   end

   always_comb begin
      merged_word = word;
      case (size)
         SZ_BYTE: merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
         SZ_HALF: merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
         default: merged_word = wdata;
      endcase
   end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit for the MEM stage, driving a word-only data memory.
//   clk, reset           : clock, synchronous active-high reset
//   req_*                : pipeline request (valid/ready handshake)
//   resp_valid/rdata/err : one-cycle completion pulse with load data or error
//   mem_write/read/addr/din, mem_dout : memory port (dout is combinational)
// Sub-word stores are read-modify-write: ACCESS reads the old word, MERGE_WR writes it back.
module dmem_lsu
   import dmem_lsu_pkg::*;
#(
   parameter int unsigned MEM_AW = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_write,
   output logic        mem_read,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   state_e              state_q, state_d;
   logic                we_q, we_d;
   logic [1:0]          size_q, size_d;
   logic                uns_q, uns_d;
   logic [MEM_AW+1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [31:0]         merged_q, merged_d;

   logic [31:0]         load_ext;
   logic [31:0]         merged_word;

   // Address bits above the memory range alias and are deliberately dropped.
   logic                unused_addr_hi;
   assign unused_addr_hi = ^req_addr[31:MEM_AW+2];

   dmem_lane_align u_lane_align (
      .word        (mem_dout),
      .addr_lo     (addr_q[1:0]),
      .size        (size_q),
      .uns         (uns_q),
      .wdata       (wdata_q),
      .load_ext    (load_ext),
      .merged_word (merged_word)
   );

   assign mem_addr = {{(32 - MEM_AW){1'b0}}, addr_q[MEM_AW+1:2]};

   always_comb begin
      state_d    = state_q;
      we_d       = we_q;
      size_d     = size_q;
      uns_d      = uns_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      err_d      = err_q;
      rdata_d    = rdata_q;
      merged_d   = merged_q;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = rdata_q;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      mem_din    = '0;

      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               we_d    = req_we;
               size_d  = req_size;
               uns_d   = req_unsigned;
               addr_d  = req_addr[MEM_AW+1:0];
               wdata_d = req_wdata;
               rdata_d = '0;
               err_d   = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]);
               state_d = err_d ? RESP : ACCESS;
            end
         end
         ACCESS: begin
            if (!we_q) begin
               mem_read = !reset;
               rdata_d  = load_ext;
               state_d  = RESP;
            end else if (size_q == SZ_WORD) begin
               mem_write = !reset;
               mem_din   = wdata_q;
               state_d   = RESP;
            end else begin
               // Sub-word store: fetch old word and capture the merge for next cycle.
               mem_read = !reset;
               merged_d = merged_word;
               state_d  = MERGE_WR;
            end
         end
         MERGE_WR: begin
            mem_write = !reset;
            mem_din   = merged_q;
            state_d   = RESP;
         end
         RESP: begin
            resp_valid = !reset;
            resp_err   = !reset && err_q;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         size_q   <= SZ_BYTE;
         uns_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
         merged_q <= '0;
      end else begin
         state_q  <= state_d;
         we_q     <= we_d;
         size_q   <= size_d;
         uns_q    <= uns_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
         merged_q <= merged_d;
      end
   end

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: directed vector table, reset corner cases,
// and randomized traffic checked against a byte-level reference memory model.
module tb_dmem_lsu;
   import dmem_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_write;
   logic        mem_read;
   logic [31:0] mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;

   int n_chk  = 0;
   int n_pass = 0;

   logic [31:0] dev_mem [1024];
   logic [31:0] ref_mem [1024];

   always #5 clk = ~clk;

   dmem_lsu #(.MEM_AW(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_write    (mem_write),
      .mem_read     (mem_read),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   // Word memory device: combinational read, cleared alongside the LSU reset.
   assign mem_dout = dev_mem[mem_addr[9:0]];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 1024; i++) dev_mem[i] <= '0;
      end else if (mem_write) begin
         dev_mem[mem_addr[9:0]] <= mem_din;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else n_pass++;
   endtask

   // Per-cycle invariants, sampled just before the edge.
   always @(posedge clk) begin
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (reset) chk("no_strobe_in_reset", {30'b0, mem_read, mem_write}, 32'd0);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   // Reference model: byte-addressed semantics on a word array.
   task automatic model(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr, output logic [31:0] din);
      int idx;
      int off;
      logic [31:0] w;
      idx   = int'(addr[11:2]);
      off   = int'(addr[1:0]);
      rdata = '0;
      din   = '0;
      err   = (size == 2'b11) || (size == 2'b01 && off % 2 != 0) || (size == 2'b10 && off != 0);
      if (err) begin
         lat = 1; nrd = 0; nwr = 0;
      end else if (!we) begin
         lat = 2; nrd = 1; nwr = 0;
         w = ref_mem[idx];
         if (size == 2'b00) begin
            rdata = (w >> (8 * off)) & 32'hFF;
            if (!uns && rdata[7]) rdata = rdata | 32'hFFFF_FF00;
         end else if (size == 2'b01) begin
            rdata = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && rdata[15]) rdata = rdata | 32'hFFFF_0000;
         end else begin
            rdata = w;
         end
      end else begin
         nwr = 1;
         if (size == 2'b10) begin
            lat = 2; nrd = 0;
            ref_mem[idx] = wdata;
         end else begin
            lat = 3; nrd = 1;
            if (size == 2'b00) ref_mem[idx][8 * off +: 8] = wdata[7:0];
            else               ref_mem[idx][8 * off +: 16] = wdata[15:0];
         end
         din = ref_mem[idx];
      end
   endtask

   task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int nrd, output int nwr, output logic [31:0] wdin,
                          output logic [31:0] waddr);
      int waits = 0;
      rdata = '0; err = 1'b0; lat = 0; nrd = 0; nwr = 0; wdin = '0; waddr = '0;
      while (!req_ready && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         chk("ready_timeout", 32'd0, 32'd1);
         return;
      end
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(negedge clk);
      req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (mem_read) nrd++;
         if (mem_write) begin
            nwr++;
            wdin  = mem_din;
            waddr = mem_addr;
         end
         if (resp_valid) begin
            rdata = resp_rdata;
            err   = resp_err;
            lat   = k;
            break;
         end
         @(negedge clk);
      end
      if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          exp_nrd;
      int          exp_nwr;
      logic [31:0] exp_din;
   } vec_t;

   vec_t vecs [13];

   initial begin
      logic [31:0] rd, wdin, waddr, m_rd, m_din;
      logic        er, m_er;
      int          lat, nrd, nwr, m_lat, m_nrd, m_nwr;
      string       tag;

      //           we    size   uns   addr        wdata          rdata          err  lat rd wr din
      vecs[0]  = '{1'b1, 2'b10, 1'b0, 32'h10,     32'hDEADBEEF, 32'h0,         1'b0, 2, 0, 1, 32'hDEADBEEF};
      vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h10,     32'h0,        32'hDEADBEEF,  1'b0, 2, 1, 0, 32'h0};
      vecs[2]  = '{1'b1, 2'b10, 1'b0, 32'h10,     32'h11223344, 32'h0,         1'b0, 2, 0, 1, 32'h11223344};
      vecs[3]  = '{1'b1, 2'b00, 1'b0, 32'h11,     32'h000000A5, 32'h0,         1'b0, 3, 1, 1, 32'h1122A544};
      vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h11,     32'h0,        32'hFFFFFFA5,  1'b0, 2, 1, 0, 32'h0};
      vecs[5]  = '{1'b0, 2'b00, 1'b1, 32'h11,     32'h0,        32'h000000A5,  1'b0, 2, 1, 0, 32'h0};
      vecs[6]  = '{1'b0, 2'b01, 1'b0, 32'h12,     32'h0,        32'h00001122,  1'b0, 2, 1, 0, 32'h0};
      vecs[7]  = '{1'b0, 2'b01, 1'b0, 32'h13,     32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
      vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h12,     32'hCAFEF00D, 32'h0,         1'b1, 1, 0, 0, 32'h0};
      vecs[9]  = '{1'b0, 2'b11, 1'b0, 32'h10,     32'h0,        32'h0,         1'b1, 1, 0, 0, 32'h0};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h12,     32'h1234BEEF, 32'h0,         1'b0, 3, 1, 1, 32'hBEEFA544};
      vecs[11] = '{1'b0, 2'b01, 1'b0, 32'h12,     32'h0,        32'hFFFFBEEF,  1'b0, 2, 1, 0, 32'h0};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h1010,   32'h0,        32'hBEEFA544,  1'b0, 2, 1, 0, 32'h0};

      // Reset with a store presented: nothing may happen.
      reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_addr = 32'h10; req_wdata = 32'h12345678;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
         chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
      end
      req_valid = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_din", mem_din, 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("idle_ready", {31'b0, req_ready}, 32'd1);
         chk("idle_strobes", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
      end
      chk("rst_store_dropped", dev_mem[4], 32'd0);

      // Directed vector table.
      foreach (vecs[i]) begin
         model(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
               m_rd, m_er, m_lat, m_nrd, m_nwr, m_din);
         run_req(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata,
                 rd, er, lat, nrd, nwr, wdin, waddr);
         tag = $sformatf("v%0d", i);
         chk({tag, "_rdata"}, rd, vecs[i].exp_rdata);
         chk({tag, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
         chk({tag, "_lat"}, lat, vecs[i].exp_lat);
         chk({tag, "_nrd"}, nrd, vecs[i].exp_nrd);
         chk({tag, "_nwr"}, nwr, vecs[i].exp_nwr);
         if (vecs[i].exp_nwr != 0) begin
            chk({tag, "_din"}, wdin, vecs[i].exp_din);
            chk({tag, "_waddr"}, waddr, {22'b0, vecs[i].addr[11:2]});
         end
      end

      // Reset landing in MERGE_WR of a byte store.
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
      req_addr = 32'h21; req_wdata = 32'h5A;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rmw_rd_phase", {30'b0, mem_read, mem_write}, 32'd2);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_merge_no_write", {31'b0, mem_write}, 32'd0);
      chk("rst_merge_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      chk("post_rst_ready", {31'b0, req_ready}, 32'd1);
      chk("post_rst_no_resp", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("post_rst_ready2", {31'b0, req_ready}, 32'd1);
      chk("post_rst_idle", {29'b0, resp_valid, mem_read, mem_write}, 32'd0);
      chk("post_rst_mem", dev_mem[8], 32'd0);

      // Randomized traffic over 16 words, with aliasing upper address bits.
      for (int n = 0; n < 300; n++) begin
         logic        we, uns;
         logic [1:0]  sz;
         logic [31:0] addr, wd;
         we   = 1'($urandom_range(0, 1));
         uns  = 1'($urandom_range(0, 1));
         sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         addr = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
         wd   = $urandom;
         model(we, sz, uns, addr, wd, m_rd, m_er, m_lat, m_nrd, m_nwr, m_din);
         run_req(we, sz, uns, addr, wd, rd, er, lat, nrd, nwr, wdin, waddr);
         tag = $sformatf("r%0d_a%h_s%0d_we%0d", n, addr, sz, we);
         chk({tag, "_rdata"}, rd, m_rd);
         chk({tag, "_err"}, {31'b0, er}, {31'b0, m_er});
         chk({tag, "_lat"}, lat, m_lat);
         chk({tag, "_nrd"}, nrd, m_nrd);
         chk({tag, "_nwr"}, nwr, m_nwr);
         if (m_nwr != 0) chk({tag, "_din"}, wdin, m_din);
      end

      @(negedge clk);
      for (int i = 0; i < 16; i++) chk($sformatf("final_mem%0d", i), dev_mem[i], ref_mem[i]);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
